// File: rtl/fft_bist_if.sv
// rtl/fft_bist_if.sv - stimulus/golden ROM and FFT-under-test signal bundle for fft_bist
interface fft_bist_if #(
  parameter int N_POINT = 32,
  parameter int IN_W    = 11,
  parameter int OUT_W   = 17
);
  localparam int SA_W = $clog2(N_POINT);
  localparam int GA_W = $clog2(2*N_POINT);

  logic [SA_W-1:0]  stim_addr;
  logic [IN_W-1:0]  stim_data;
  logic [GA_W-1:0]  gold_addr;
  logic [OUT_W-1:0] gold_data;
  logic             dut_valid;
  logic [IN_W-1:0]  dut_x;
  logic             dut_finish;
  logic [OUT_W-1:0] dut_answer;

  modport master (
    output stim_addr, gold_addr, dut_valid, dut_x,
    input  stim_data, gold_data, dut_finish, dut_answer
  );

  modport slave (
    input  stim_addr, gold_addr, dut_valid, dut_x,
    output stim_data, gold_data, dut_finish, dut_answer
  );
endinterface

// File: rtl/fft_bist.sv
// rtl/fft_bist.sv - FFT built-in self test: feeds N stimulus samples, checks 2N answers against golden ROM
// Optional FFT_BIST_FIRST_ERR_EN adds first_err_idx/first_err_val capture of the first mismatch.
module fft_bist #(
  parameter int N_POINT = 32,
  parameter int IN_W    = 11,
  parameter int OUT_W   = 17,
  parameter int TIMEOUT = 150,
  parameter int ERR_W   = $clog2(2*N_POINT+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  fft_bist_if.master       bus,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [ERR_W-1:0] err_count
`ifdef FFT_BIST_FIRST_ERR_EN
  ,
  output logic [$clog2(2*N_POINT)-1:0] first_err_idx,
  output logic [OUT_W-1:0]             first_err_val
`endif
);
  localparam int SA_W = $clog2(N_POINT);
  localparam int GA_W = $clog2(2*N_POINT);
  localparam int FC_W = SA_W + 1;
  localparam int OC_W = GA_W + 1;
  localparam int CW   = $clog2(TIMEOUT + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [FC_W-1:0]  feed_cnt_q, feed_cnt_d;
  logic [OC_W-1:0]  out_cnt_q, out_cnt_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             valid_q, valid_d;
  logic [IN_W-1:0]  x_q, x_d;

  logic accept;
  logic check;
  logic mismatch;

  assign accept   = start && (state_q == S_IDLE || state_q == S_DONE);
  assign check    = bus.dut_finish && (state_q == S_FEED || state_q == S_DRAIN);
  assign mismatch = check && (bus.dut_answer != bus.gold_data);

  always_comb begin
    state_d    = state_q;
    feed_cnt_d = feed_cnt_q;
    out_cnt_d  = out_cnt_q;
    cyc_d      = cyc_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    err_d      = err_q;
    valid_d    = 1'b0;
    x_d        = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d    = S_FEED;
          feed_cnt_d = '0;
          out_cnt_d  = '0;
          cyc_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          err_d      = '0;
        end
      end
      S_FEED, S_DRAIN: begin
        cyc_d = cyc_q + CW'(1);
        if (state_q == S_FEED) begin
          if (feed_cnt_q == FC_W'(N_POINT)) begin
            state_d = S_DRAIN;
          end else begin
            valid_d    = 1'b1;
            x_d        = bus.stim_data;
            feed_cnt_d = feed_cnt_q + FC_W'(1);
          end
        end
        if (check) begin
          out_cnt_d = out_cnt_q + OC_W'(1);
          if (mismatch && err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
        end
        // The final word wins over a timeout landing on the same edge.
        if (check && out_cnt_q == OC_W'(2*N_POINT-1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          valid_d = 1'b0;
          x_d     = '0;
        end else if (cyc_q == CW'(TIMEOUT-1)) begin
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          valid_d   = 1'b0;
          x_d       = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      feed_cnt_q <= '0;
      out_cnt_q  <= '0;
      cyc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= '0;
      valid_q    <= 1'b0;
      x_q        <= '0;
    end else begin
      state_q    <= state_d;
      feed_cnt_q <= feed_cnt_d;
      out_cnt_q  <= out_cnt_d;
      cyc_q      <= cyc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      x_q        <= x_d;
    end
  end

  assign bus.stim_addr = feed_cnt_q[SA_W-1:0];
  assign bus.gold_addr = out_cnt_q[GA_W-1:0];
  assign bus.dut_valid = valid_q;
  assign bus.dut_x     = x_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign err_count     = err_q;

`ifdef FFT_BIST_FIRST_ERR_EN
  logic [GA_W-1:0]  first_idx_q, first_idx_d;
  logic [OUT_W-1:0] first_val_q, first_val_d;

  // A zero error count means no mismatch has been captured yet in this test.
  always_comb begin
    first_idx_d = first_idx_q;
    first_val_d = first_val_q;
    if (accept) begin
      first_idx_d = '0;
      first_val_d = '0;
    end else if (mismatch && err_q == '0) begin
      first_idx_d = out_cnt_q[GA_W-1:0];
      first_val_d = bus.dut_answer;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_idx_q <= '0;
      first_val_q <= '0;
    end else begin
      first_idx_q <= first_idx_d;
      first_val_q <= first_val_d;
    end
  end

  assign first_err_idx = first_idx_q;
  assign first_err_val = first_val_q;
`endif
endmodule

// File: tb/tb_fft_bist.sv
// tb/tb_fft_bist.sv - self-checking bench for fft_bist: scenario table, randomized scenarios, abort and saturation sequences
module tb_fft_bist;
  localparam int N   = 32;
  localparam int NW  = 2*N;
  localparam int TMO = 150;
  localparam int N8  = 8;

  logic clk = 1'b0;
  logic rst;
  logic start, start8;
  logic busy, done, pass, timeout;
  logic [6:0] err_count;
  logic busy8, done8, pass8, timeout8;
  logic [2:0] err8;
`ifdef FFT_BIST_FIRST_ERR_EN
  logic [5:0]  first_err_idx;
  logic [16:0] first_err_val;
  logic [3:0]  first_err_idx8;
  logic [16:0] first_err_val8;
`endif

  int checks = 0;
  int failures = 0;

  fft_bist_if #(.N_POINT(N),  .IN_W(11), .OUT_W(17)) bus ();
  fft_bist_if #(.N_POINT(N8), .IN_W(11), .OUT_W(17)) bus8 ();

  logic [10:0] stim_rom  [N];
  logic [16:0] gold_rom  [NW];
  logic [10:0] stim_rom8 [N8];
  logic [16:0] gold_rom8 [2*N8];

  assign bus.stim_data  = stim_rom[bus.stim_addr];
  assign bus.gold_data  = gold_rom[bus.gold_addr];
  assign bus8.stim_data = stim_rom8[bus8.stim_addr];
  assign bus8.gold_data = gold_rom8[bus8.gold_addr];

  fft_bist #(.N_POINT(N), .IN_W(11), .OUT_W(17), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count)
`ifdef FFT_BIST_FIRST_ERR_EN
    , .first_err_idx(first_err_idx), .first_err_val(first_err_val)
`endif
  );

  fft_bist #(.N_POINT(N8), .IN_W(11), .OUT_W(17), .TIMEOUT(TMO), .ERR_W(3)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .bus(bus8),
    .busy(busy8), .done(done8), .pass(pass8), .timeout(timeout8), .err_count(err8)
`ifdef FFT_BIST_FIRST_ERR_EN
    , .first_err_idx(first_err_idx8), .first_err_val(first_err_val8)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          s;
    bit          gap;
    int          nw;
    int          extra;
    logic [63:0] cmask;
    bit          exp_pass;
    bit          exp_to;
    int          exp_err;
    int          exp_done;
  } scen_t;

  scen_t tbl [$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic scen_t mk(input int s, input bit gap, input int nw, input int extra,
                               input logic [63:0] cmask, input bit ep, input bit eto,
                               input int eerr, input int edone);
    scen_t r;
    r.s = s; r.gap = gap; r.nw = nw; r.extra = extra; r.cmask = cmask;
    r.exp_pass = ep; r.exp_to = eto; r.exp_err = eerr; r.exp_done = edone;
    return r;
  endfunction

  task automatic fill_roms();
    for (int i = 0; i < N; i++)  stim_rom[i] = 11'($urandom);
    for (int i = 0; i < NW; i++) gold_rom[i] = 17'($urandom);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_valid"}, bus.dut_valid, 0);
    chk({tag, "_x"}, bus.dut_x, 0);
    chk({tag, "_saddr"}, bus.stim_addr, 0);
    chk({tag, "_gaddr"}, bus.gold_addr, 0);
  endtask

  task automatic run_scen(input scen_t sc, input string nm);
    int w, done_cyc, last_drv, nbad, first_idx;
    logic busy_mid;
    logic [10:0] smp [$];
    fill_roms();
    w = 0; done_cyc = -1; last_drv = -1; busy_mid = 1'b0; first_idx = -1;
    for (int i = 0; i < NW; i++) if (sc.cmask[i] && first_idx < 0) first_idx = i;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.dut_valid) smp.push_back(bus.dut_x);
      if (cyc == 2) busy_mid = busy;
      if (done_cyc < 0 && done) done_cyc = cyc;
      if (done_cyc >= 0 && cyc >= done_cyc + 8) break;
      bus.dut_finish = 1'b0;
      bus.dut_answer = '0;
      if (cyc >= sc.s && (!sc.gap || ((cyc - sc.s) % 2 == 0)) && w < sc.nw + sc.extra) begin
        bus.dut_finish = 1'b1;
        if (w < NW) bus.dut_answer = sc.cmask[w] ? ~gold_rom[w] : gold_rom[w];
        else        bus.dut_answer = 17'($urandom);
        if (w == NW-1) last_drv = cyc;
        w++;
      end
    end
    bus.dut_finish = 1'b0;
    bus.dut_answer = '0;
    nbad = 0;
    foreach (smp[i]) if (i < N && smp[i] !== stim_rom[i]) nbad++;
    chk({nm, "_busy_mid"}, busy_mid, 1);
    chk({nm, "_valid_count"}, smp.size(), N);
    chk({nm, "_stim_order_bad"}, nbad, 0);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy_end"}, busy, 0);
    chk({nm, "_timeout"}, timeout, sc.exp_to);
    chk({nm, "_pass"}, pass, sc.exp_pass);
    chk({nm, "_err"}, err_count, sc.exp_err);
    chk({nm, "_done_cycle"}, done_cyc, (sc.exp_done >= 0) ? sc.exp_done : last_drv + 1);
`ifdef FFT_BIST_FIRST_ERR_EN
    chk({nm, "_first_idx"}, first_err_idx, (first_idx < 0) ? 0 : first_idx);
    chk({nm, "_first_val"}, first_err_val, (first_idx < 0) ? 0 : 64'(~gold_rom[first_idx]));
`endif
  endtask

  initial begin
    scen_t sc;
    int cnt, dc;
    logic busy_chk;
    rst = 1'b1; start = 1'b0; start8 = 1'b0;
    bus.dut_finish = 1'b0;  bus.dut_answer = '0;
    bus8.dut_finish = 1'b0; bus8.dut_answer = '0;
    fill_roms();
    for (int i = 0; i < N8; i++)   stim_rom8[i] = 11'($urandom);
    for (int i = 0; i < 2*N8; i++) gold_rom8[i] = 17'($urandom);
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;

    tbl.push_back(mk(42, 0, 64, 0, 64'h0, 1, 0, 0, -1));
    tbl.push_back(mk(42, 0, 64, 0, (64'h1 << 5) | (64'h1 << 40), 0, 0, 2, -1));
    tbl.push_back(mk(42, 0, 63, 0, 64'h0, 0, 1, 0, TMO));
    tbl.push_back(mk(0, 1, 64, 3, 64'h0, 1, 0, 0, -1));
    tbl.push_back(mk(86, 0, 64, 0, 64'h0, 1, 0, 0, TMO));
    tbl.push_back(mk(0, 0, 64, 0, (64'h1 << 0) | (64'h1 << 63), 0, 0, 2, -1));
    for (int k = 0; k < 6; k++) begin
      sc.gap   = bit'($urandom % 2);
      sc.s     = sc.gap ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 60));
      sc.nw    = NW;
      sc.extra = int'($urandom_range(0, 2));
      sc.cmask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      sc.exp_err  = $countones(sc.cmask);
      sc.exp_pass = (sc.exp_err == 0);
      sc.exp_to   = 1'b0;
      sc.exp_done = -1;
      tbl.push_back(sc);
    end
    foreach (tbl[i]) run_scen(tbl[i], $sformatf("scen%0d", i));

    // start during FEED must be ignored, then reset mid-DRAIN aborts
    fill_roms();
    cnt = 0; busy_chk = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      start = (cyc == 10);
      if (bus.dut_valid) cnt++;
      if (cyc == 39) busy_chk = busy;
    end
    start = 1'b0;
    chk("abort_valid_count", cnt, N);
    chk("abort_busy_drain", busy_chk, 1);
    #2 rst = 1'b1;
    #1 check_idle_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    run_scen(mk(42, 0, 64, 0, 64'h0, 1, 0, 0, -1), "after_abort");

    // N=8, every word wrong, 3-bit error counter saturates
    dc = -1;
    @(negedge clk);
    start8 = 1'b1;
    @(posedge clk);
    begin
      int w8;
      w8 = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
        @(negedge clk);
        start8 = 1'b0;
        if (cyc == 12) chk("n8_err_mid", err8, 7);
        if (done8) begin
          dc = cyc;
          break;
        end
        bus8.dut_finish = (w8 < 2*N8);
        bus8.dut_answer = (w8 < 2*N8) ? ~gold_rom8[w8] : '0;
        w8++;
      end
    end
    bus8.dut_finish = 1'b0;
    chk("n8_done_cycle", dc, 2*N8);
    chk("n8_done", done8, 1);
    chk("n8_err_sat", err8, 7);
    chk("n8_pass", pass8, 0);
    chk("n8_timeout", timeout8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_bist.md
FFT_BIST -- requirements
Module: fft_bist

Interface
REQ-001 Parameter N_POINT, default 32, number of complex FFT points (power of two, 8..1024).
REQ-002 Parameter IN_W, default 11, width of one real input sample.
REQ-003 Parameter OUT_W, default 17, width of one output word.
REQ-004 Parameter TIMEOUT, default 150, maximum cycles from start to last checked output.
REQ-005 Parameter ERR_W, default $clog2(2*N_POINT+1), width of err_count.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to run one test.
REQ-009 stim_addr  out  $clog2(N_POINT)  stimulus ROM address.
REQ-010 stim_data  in  IN_W  stimulus ROM data, combinational from stim_addr.
REQ-011 gold_addr  out  $clog2(2*N_POINT)  golden ROM address.
REQ-012 gold_data  in  OUT_W  golden ROM data, combinational from gold_addr.
REQ-013 dut_valid  out  1  sample valid to the FFT.
REQ-014 dut_x  out  IN_W  real sample to the FFT.
REQ-015 dut_finish  in  1  FFT output word valid.
REQ-016 dut_answer  in  OUT_W  FFT output word: words 0..N-1 real, N..2N-1 imaginary.
REQ-017 busy  out  1  test in progress.
REQ-018 done  out  1  test complete; held until the next accepted start.
REQ-019 pass  out  1  valid while done: 2N words checked, zero errors, no timeout.
REQ-020 timeout  out  1  valid while done: TIMEOUT reached before 2N words.
REQ-021 err_count  out  ERR_W  mismatch count, saturating at 2^ERR_W-1.

Function
REQ-022 FSM states IDLE, FEED, DRAIN, DONE; reset state IDLE.
REQ-023 start is sampled only in IDLE or DONE and is ignored while busy.
REQ-024 Accepted start at edge E0: go to FEED; clear done, pass, timeout, err_count and both counters; set busy.
REQ-025 FEED: stim_addr = feed counter; at edge E1+i (i=0..N-1) dut_valid<=1 and dut_x<=stim_data at address i.
REQ-026 At edge E1+N: dut_valid<=0, dut_x<=0, state DRAIN.
REQ-027 Outside FEED, dut_valid and dut_x are 0.
REQ-028 In FEED and DRAIN, gold_addr = output counter; each rising edge with dut_finish=1 compares dut_answer to gold_data, increments err_count on mismatch, increments the output counter.
REQ-029 Gaps in dut_finish are legal; dut_finish pulses before the first dut_valid are checked.
REQ-030 On the edge that checks word 2N-1: state DONE, busy<=0, done<=1; pass<=1 iff the final error count is 0.
REQ-031 Cycle counter starts at E0; when it reaches TIMEOUT with fewer than 2N words checked: state DONE, timeout<=1, pass<=0.
REQ-032 If the last word and the timeout fall on the same edge, the word is checked and timeout stays 0.
REQ-033 dut_finish is ignored in IDLE and DONE.
REQ-034 err_count holds at 2^ERR_W-1 once reached.

Reset
REQ-035 While rst=1 (asynchronous): state IDLE, all counters 0; busy, done, pass, timeout, dut_valid, dut_x, err_count, stim_addr, gold_addr all 0.
REQ-036 Reset mid-test aborts the test; the next start after release runs a complete new test.

Configuration
REQ-037 With FFT_BIST_FIRST_ERR_EN defined, add outputs first_err_idx ($clog2(2*N_POINT)) and first_err_val (OUT_W), which capture the word index and the dut_answer of the first mismatch in a test; they are cleared by reset and by an accepted start, and are 0 if no mismatch occurs.
REQ-038 Without FFT_BIST_FIRST_ERR_EN, neither port nor its capture logic exists; all other behaviour is unchanged.

Verification
REQ-039 N=32; start; the DUT model returns all 64 golden words 10 cycles after the last dut_valid -> dut_valid high for exactly 32 cycles with stim[0..31] in order; done=1, pass=1, err_count=0.
REQ-040 Same as REQ-039 with words 5 and 40 corrupted -> pass=0, err_count=2; with the macro defined, first_err_idx=5.
REQ-041 DUT model returns only 63 words, TIMEOUT=150 -> done at cycle 150 after E0; timeout=1, pass=0.
REQ-042 Outputs with dut_finish toggled every other cycle, plus 3 extra words after word 63 -> pass=1, and the extra words do not change err_count.
REQ-043 start pulsed during FEED, then rst asserted mid-DRAIN -> start ignored; all outputs 0 immediately; a second start afterwards gives pass=1.
REQ-044 N_POINT=8, all 16 words wrong, ERR_W=3 -> err_count saturates at 7; pass=0.
